// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: instruction memory request/response, redirect, and the
// fetch-to-decode queue head.
interface fetch_unit_if #(
   parameter int XLEN = 32
);
   logic            im_req;
   logic [XLEN-1:0] im_addr;
   logic            im_gnt;
   logic            im_rvalid;
   logic [31:0]     im_rdata;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic            fd_valid;
   logic            fd_ready;
   logic [31:0]     fd_inst;
   logic [XLEN-1:0] fd_pc;
   logic            fd_misaligned;

   modport master (
      output im_req, im_addr, fd_valid, fd_inst, fd_pc, fd_misaligned,
      input  im_gnt, im_rvalid, im_rdata, redirect, redirect_pc, fd_ready
   );

   modport slave (
      input  im_req, im_addr, fd_valid, fd_inst, fd_pc, fd_misaligned,
      output im_gnt, im_rvalid, im_rdata, redirect, redirect_pc, fd_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// In-order instruction fetch: credit-limited requests into a DEPTH-entry queue,
// redirect flush with stale-response dropping, and misaligned-target fault entry.
module fetch_unit #(
   parameter int              XLEN         = 32,
   parameter int              DEPTH        = 4,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
   input logic          clk,
   input logic          resetb,
   fetch_unit_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   typedef enum logic {RUN, MISALIGNED} state_t;

   typedef struct packed {
      logic [31:0]     inst;
      logic [XLEN-1:0] pc;
      logic            mis;
   } fq_ent_t;

   state_t          state;
   logic            started;
   logic            mis_pend;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] rsp_pc;
   logic [CW-1:0]   inflight;
   logic [CW-1:0]   drop;
   logic [CW-1:0]   count;
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   fq_ent_t         fq [DEPTH];

   logic [CW:0]     credit;
   logic            grant;
   logic            rv;
   logic            push_data;
   logic            mis_push;
   logic            push;
   logic            pop;
   fq_ent_t         push_ent;
   fq_ent_t         head;

   assign credit = {1'b0, inflight} + {1'b0, count};

   // started holds off requests for the first cycle after reset release
   assign bus.im_req  = resetb && started && (state == RUN) && !bus.redirect && (credit < DEPTH_C);
   assign bus.im_addr = fetch_pc;
   assign grant       = bus.im_req && bus.im_gnt;

   // responses with nothing outstanding are leftovers from before a reset
   assign rv        = bus.im_rvalid && (inflight != '0);
   assign push_data = rv && (drop == '0) && !bus.redirect && (state == RUN);
   assign mis_push  = (state == MISALIGNED) && mis_pend && (drop == '0) && !bus.redirect;
   assign push      = push_data || mis_push;
   assign pop       = (count != '0) && bus.fd_ready && !bus.redirect;

   always_comb begin
      push_ent = '{inst: bus.im_rdata, pc: rsp_pc, mis: 1'b0};
      if (mis_push) push_ent = '{inst: 32'h0000_0013, pc: rsp_pc, mis: 1'b1};
   end

   assign head              = fq[rd_ptr];
   assign bus.fd_valid      = resetb && (count != '0);
   assign bus.fd_inst       = resetb ? head.inst : '0;
   assign bus.fd_pc         = resetb ? head.pc   : '0;
   assign bus.fd_misaligned = resetb ? head.mis  : 1'b0;

   always_ff @(posedge clk) begin
      if (!resetb) begin
         state    <= RUN;
         started  <= 1'b0;
         mis_pend <= 1'b0;
         fetch_pc <= RESET_VECTOR;
         rsp_pc   <= RESET_VECTOR;
         inflight <= '0;
         drop     <= '0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         started  <= 1'b1;
         inflight <= inflight + CW'(grant) - CW'(rv);
         if (bus.redirect) begin
            // every response still owed belongs to the abandoned stream
            fetch_pc <= bus.redirect_pc;
            rsp_pc   <= bus.redirect_pc;
            drop     <= inflight - CW'(rv);
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            if (bus.redirect_pc[1:0] != 2'b00) begin
               state    <= MISALIGNED;
               mis_pend <= 1'b1;
            end else begin
               state    <= RUN;
               mis_pend <= 1'b0;
            end
         end else begin
            if (grant)              fetch_pc <= fetch_pc + XLEN'(4);
            if (rv && drop != '0)   drop     <= drop - CW'(1);
            if (push_data)          rsp_pc   <= rsp_pc + XLEN'(4);
            if (mis_push)           mis_pend <= 1'b0;
            if (push) begin
               fq[wr_ptr] <= push_ent;
               wr_ptr     <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model with configurable latency, a
// redirect vector table, and hand sequences for reset, back-pressure and random traffic.
module tb_fetch_unit;
   logic clk = 1'b0;
   logic resetb;
   always #5 clk = ~clk;

   fetch_unit_if #(.XLEN(32)) bus ();
   fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_VECTOR(32'h0)) dut (
      .clk(clk), .resetb(resetb), .bus(bus));

   typedef struct { logic [31:0] addr; int unsigned due; } pend_t;
   typedef struct { logic [31:0] pc; logic [31:0] inst; logic mis; } ent_t;
   typedef struct { int lat; logic [31:0] rpc; int n; logic [31:0] e0, e1, e2; logic mis; } vec_t;

   pend_t       pend[$];
   ent_t        got[$];
   int unsigned cyc = 0;
   int          lat_lo = 1, lat_hi = 1;
   logic        gnt_rand = 0, gnt_off = 0, rdy_rand = 0, rdy_val = 1;
   logic        smp_req, smp_fdv, req_seen, fdv_seen;
   logic [31:0] smp_fdpc;
   int          max_occ = 0;
   int          n_cmp = 0, n_bad = 0;
   vec_t        vt [6];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // one clock: drive memory/decode inputs at the falling edge, sample, then cross the rising edge
   task automatic tick();
      logic rv, fire, popd;
      int   occ;
      @(negedge clk);
      bus.im_gnt   = gnt_off ? 1'b0 : (gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      bus.fd_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
      rv = (pend.size() != 0) && (pend[0].due <= cyc);
      bus.im_rvalid = rv;
      bus.im_rdata  = rv ? mem_word(pend[0].addr) : 32'hDEAD_BEEF;
      #1;
      smp_req  = bus.im_req;
      smp_fdv  = bus.fd_valid;
      smp_fdpc = bus.fd_pc;
      if (smp_req) req_seen = 1'b1;
      if (smp_fdv) fdv_seen = 1'b1;
      occ = int'(dut.inflight) + int'(dut.count);
      if (occ > max_occ) max_occ = occ;
      fire = bus.im_req && bus.im_gnt;
      popd = bus.fd_valid && bus.fd_ready && !bus.redirect;
      if (popd) got.push_back('{bus.fd_pc, bus.fd_inst, bus.fd_misaligned});
      @(posedge clk);
      if (rv) void'(pend.pop_front());
      if (fire) pend.push_back('{bus.im_addr, cyc + $urandom_range(lat_lo, lat_hi)});
      cyc++;
      #1;
   endtask

   task automatic run_until(input int n, input int budget, input string name);
      int t = 0;
      while (got.size() < n && t < budget) begin tick(); t++; end
      chk({name, "_timeout"}, 64'(got.size() >= n), 64'd1);
   endtask

   task automatic do_redirect(input logic [31:0] pc);
      bus.redirect = 1'b1;
      bus.redirect_pc = pc;
      tick();
      bus.redirect = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      resetb = 1'b0;
      bus.redirect = 1'b0; bus.redirect_pc = '0;
      bus.im_gnt = 1'b1; bus.im_rvalid = 1'b0; bus.im_rdata = '0; bus.fd_ready = 1'b1;

      vt[0] = '{2, 32'h0000_0100, 3, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108, 1'b0};
      vt[1] = '{1, 32'hFFFF_FFF8, 3, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0};
      vt[2] = '{3, 32'h0000_0040, 3, 32'h0000_0040, 32'h0000_0044, 32'h0000_0048, 1'b0};
      vt[3] = '{2, 32'h0000_0102, 1, 32'h0000_0102, 32'h0, 32'h0, 1'b1};
      vt[4] = '{2, 32'h0000_0201, 1, 32'h0000_0201, 32'h0, 32'h0, 1'b1};
      vt[5] = '{1, 32'h0000_0004, 3, 32'h0000_0004, 32'h0000_0008, 32'h0000_000C, 1'b0};

      // reset state
      repeat (3) tick();
      chk("rst_im_req", bus.im_req, 0);
      chk("rst_fd_valid", bus.fd_valid, 0);
      chk("rst_fd_inst", bus.fd_inst, 0);
      chk("rst_fd_pc", bus.fd_pc, 0);
      chk("rst_fd_mis", bus.fd_misaligned, 0);

      // streaming start-up timing with 1-cycle memory
      got.delete();
      resetb = 1'b1;
      for (int t = 1; t <= 10; t++) begin
         tick();
         chk($sformatf("start_req_t%0d", t), smp_req, 64'(t >= 2));
         chk($sformatf("start_fdv_t%0d", t), smp_fdv, 64'(t >= 4));
         if (t >= 4) chk($sformatf("start_pc_t%0d", t), smp_fdpc, 64'((t - 4) * 4));
      end

      // back-pressure: queue fills, requests stop, nothing lost on release
      rdy_val = 1'b0;
      repeat (10) tick();
      chk("bp_count_full", dut.count, 4);
      chk("bp_im_req_low", bus.im_req, 0);
      rdy_val = 1'b1;
      repeat (15) tick();
      chk("bp_enough", 64'(got.size() >= 20), 1);
      for (int i = 0; i < got.size(); i++) begin
         chk($sformatf("bp_pc%0d", i), got[i].pc, 64'(i * 4));
         chk($sformatf("bp_inst%0d", i), got[i].inst, mem_word(32'(i * 4)));
      end

      // redirect table
      for (int v = 0; v < 6; v++) begin
         lat_lo = vt[v].lat; lat_hi = vt[v].lat;
         repeat (6) tick();
         got.delete();
         do_redirect(vt[v].rpc);
         req_seen = 1'b0;
         run_until(vt[v].n, 30, $sformatf("vec%0d", v));
         for (int k = 0; k < vt[v].n && k < got.size(); k++) begin
            logic [31:0] ep;
            ep = (k == 0) ? vt[v].e0 : (k == 1) ? vt[v].e1 : vt[v].e2;
            chk($sformatf("vec%0d_pc%0d", v, k), got[k].pc, ep);
            chk($sformatf("vec%0d_inst%0d", v, k), got[k].inst, vt[v].mis ? 32'h13 : mem_word(ep));
            chk($sformatf("vec%0d_mis%0d", v, k), got[k].mis, vt[v].mis);
         end
         if (vt[v].mis) begin
            repeat (8) tick();
            chk($sformatf("vec%0d_single", v), got.size(), 1);
            chk($sformatf("vec%0d_noreq", v), req_seen, 0);
         end
      end

      // random grant, latency 1..4 and decode stalls
      lat_lo = 1; lat_hi = 4;
      do_redirect(32'h1000);
      got.delete();
      max_occ = 0;
      gnt_rand = 1'b1; rdy_rand = 1'b1;
      repeat (400) tick();
      gnt_rand = 1'b0; rdy_rand = 1'b0;
      repeat (10) tick();
      chk("rand_enough", 64'(got.size() >= 50), 1);
      chk("rand_occ_le_depth", 64'(max_occ <= 4), 1);
      for (int i = 0; i < got.size(); i++) begin
         chk($sformatf("rand_pc%0d", i), got[i].pc, 32'h1000 + 32'(i * 4));
         chk($sformatf("rand_inst%0d", i), got[i].inst, mem_word(32'h1000 + 32'(i * 4)));
      end

      // reset mid-stream: late responses must not surface
      lat_lo = 3; lat_hi = 3;
      repeat (6) tick();
      resetb = 1'b0;
      repeat (2) tick();
      resetb = 1'b1;
      gnt_off = 1'b1;
      fdv_seen = 1'b0;
      for (int t = 0; t < 10 && pend.size() != 0; t++) tick();
      tick();
      chk("rst_mid_no_stale", fdv_seen, 0);
      gnt_off = 1'b0;
      got.delete();
      run_until(3, 20, "rst_mid");
      for (int k = 0; k < 3 && k < got.size(); k++) begin
         chk($sformatf("rst_mid_pc%0d", k), got[k].pc, 64'(k * 4));
         chk($sformatf("rst_mid_inst%0d", k), got[k].inst, mem_word(32'(k * 4)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
